// File: rtl/siaa_alu.sv
// siaa_alu: 8-bit accumulator ALU for the SIAA datapath.
// R-type and I-type ops; result and flags are registered one cycle after the operands.
module siaa_alu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] acc,
    input  logic [7:0] opReg,
    input  logic [4:0] imm,
    input  logic       typeCode,
    input  logic [3:0] rOp,
    input  logic [2:0] iOp,
    input  logic       scIn,
    output logic [7:0] rslt,
    output logic       scOut,
    output logic       zero,
    output logic       branch
);

    typedef enum logic [3:0] {
        R_ADD, R_SUB, R_AND, R_OR, R_XOR, R_RXOR, R_SLR, R_SRR,
        R_LW, R_SW, R_EQ, R_SLT, R_BR, R_J, R_SET, R_LA
    } r_op_e;

    typedef enum logic [2:0] {
        I_ADDI, I_SUBI, I_ANDI, I_SLL, I_SRL, I_SETI, I_RSV6, I_RSV7
    } i_op_e;

    r_op_e      w_rop;
    i_op_e      w_iop;
    logic [7:0] w_imm_z;
    logic [7:0] w_b;
    logic [2:0] w_sh;
    logic [8:0] w_add;
    logic [8:0] w_sub;
    logic [8:0] w_shl;
    logic [8:0] w_shr;
    logic [7:0] w_rslt;
    logic       w_sc;
    logic       w_br;

    logic [7:0] r_rslt;
    logic       r_sc;
    logic       r_zero;
    logic       r_br;

    assign w_rop   = r_op_e'(rOp);
    assign w_iop   = i_op_e'(iOp);
    assign w_imm_z = {3'b000, imm};
    assign w_b     = typeCode ? w_imm_z : opReg;
    assign w_sh    = typeCode ? imm[2:0] : opReg[2:0];

    // Bit 8 of the add/sub is the unsigned carry/borrow.
    assign w_add = {1'b0, acc} + {1'b0, w_b} + {8'b0, scIn};
    assign w_sub = {1'b0, acc} - {1'b0, w_b} - {8'b0, scIn};

    // One guard bit beside acc catches the last bit shifted out (0 when amount is 0).
    assign w_shl = {1'b0, acc} << w_sh;
    assign w_shr = {acc, 1'b0} >> w_sh;

    always_comb begin
        w_rslt = '0;
        w_sc   = 1'b0;
        w_br   = 1'b0;
        if (!typeCode) begin
            case (w_rop)
                R_ADD:        begin w_rslt = w_add[7:0]; w_sc = w_add[8]; end
                R_SUB:        begin w_rslt = w_sub[7:0]; w_sc = w_sub[8]; end
                R_AND:        w_rslt = acc & opReg;
                R_OR:         w_rslt = acc | opReg;
                R_XOR:        w_rslt = acc ^ opReg;
                R_RXOR:       w_rslt = {7'b0, ^opReg};
                R_SLR:        begin w_rslt = w_shl[7:0]; w_sc = w_shl[8]; end
                R_SRR:        begin w_rslt = w_shr[8:1]; w_sc = w_shr[0]; end
                R_LW, R_SW,
                R_LA:         w_rslt = opReg;
                R_EQ:         w_rslt = {7'b0, acc == opReg};
                R_SLT:        w_rslt = {7'b0, $signed(acc) < $signed(opReg)};
                R_BR:         begin w_rslt = opReg; w_br = |acc; end
                R_J:          begin w_rslt = opReg; w_br = 1'b1; end
                R_SET:        w_rslt = acc;
                default:      ;
            endcase
        end else begin
            case (w_iop)
                I_ADDI:       begin w_rslt = w_add[7:0]; w_sc = w_add[8]; end
                I_SUBI:       begin w_rslt = w_sub[7:0]; w_sc = w_sub[8]; end
                I_ANDI:       w_rslt = acc & w_imm_z;
                I_SLL:        begin w_rslt = w_shl[7:0]; w_sc = w_shl[8]; end
                I_SRL:        begin w_rslt = w_shr[8:1]; w_sc = w_shr[0]; end
                I_SETI:       w_rslt = w_imm_z;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rslt <= '0;
            r_sc   <= 1'b0;
            r_zero <= 1'b1;
            r_br   <= 1'b0;
        end else begin
            r_rslt <= w_rslt;
            r_sc   <= w_sc;
            r_zero <= (w_rslt == '0);
            r_br   <= w_br;
        end
    end

    assign rslt   = r_rslt;
    assign scOut  = r_sc;
    assign zero   = r_zero;
    assign branch = r_br;

endmodule

// File: tb/tb_siaa_alu.sv
// Self-checking bench for siaa_alu: directed vectors plus random back-to-back ops,
// expected results queued at drive time and popped one edge later.
module tb_siaa_alu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] acc;
    logic [7:0] opReg;
    logic [4:0] imm;
    logic       typeCode;
    logic [3:0] rOp;
    logic [2:0] iOp;
    logic       scIn;
    logic [7:0] rslt;
    logic       scOut;
    logic       zero;
    logic       branch;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       tc;
        logic [3:0] r;
        logic [2:0] i;
        logic [7:0] a;
        logic [7:0] o;
        logic [4:0] im;
        logic       s;
        logic [7:0] er;
        logic       ec;
        logic       eb;
    } vec_t;

    typedef struct packed {
        logic [7:0] r;
        logic       c;
        logic       z;
        logic       b;
    } exp_t;

    exp_t q_exp[$];

    siaa_alu dut (
        .clk(clk), .rst_n(rst_n), .acc(acc), .opReg(opReg), .imm(imm),
        .typeCode(typeCode), .rOp(rOp), .iOp(iOp), .scIn(scIn),
        .rslt(rslt), .scOut(scOut), .zero(zero), .branch(branch)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic vec_t mk(input logic tc, input logic [3:0] r, input logic [2:0] i,
                                input logic [7:0] a, input logic [7:0] o, input logic [4:0] im,
                                input logic s, input logic [7:0] er, input logic ec, input logic eb);
        vec_t v;
        v.tc = tc; v.r = r; v.i = i; v.a = a; v.o = o; v.im = im; v.s = s;
        v.er = er; v.ec = ec; v.eb = eb;
        return v;
    endfunction

    // Reference model in plain integer arithmetic.
    function automatic vec_t model(input vec_t v);
        int a, b, o, sh, res, sa, sb, ones, kind;
        logic c, br;
        a  = int'(v.a);
        o  = int'(v.o);
        b  = v.tc ? int'(v.im) : o;
        sh = v.tc ? int'(v.im) % 8 : o % 8;
        sa = (a > 127) ? a - 256 : a;
        sb = (o > 127) ? o - 256 : o;
        res = 0; c = 1'b0; br = 1'b0; ones = 0;
        if (!v.tc) kind = int'(v.r);
        else begin
            case (v.i)
                3'd0: kind = 0;
                3'd1: kind = 1;
                3'd2: kind = 2;
                3'd3: kind = 6;
                3'd4: kind = 7;
                3'd5: kind = 16;
                default: kind = 17;
            endcase
        end
        case (kind)
            0: begin res = a + b + int'(v.s); c = (res > 255); res = res % 256; end
            1: begin res = a - b - int'(v.s); c = (res < 0); if (res < 0) res = res + 256; end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: begin for (int k = 0; k < 8; k++) ones += int'(v.o[k]); res = ones % 2; end
            6: begin res = a; for (int k = 0; k < sh; k++) begin c = (((res >> 7) & 1) == 1); res = (res * 2) % 256; end end
            7: begin res = a; for (int k = 0; k < sh; k++) begin c = ((res % 2) == 1); res = res / 2; end end
            8, 9, 15: res = o;
            10: res = (a == o) ? 1 : 0;
            11: res = (sa < sb) ? 1 : 0;
            12: begin res = o; br = (a != 0); end
            13: begin res = o; br = 1'b1; end
            14: res = a;
            16: res = int'(v.im);
            default: res = 0;
        endcase
        v.er = 8'(res); v.ec = c; v.eb = br;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        typeCode = v.tc; rOp = v.r; iOp = v.i; acc = v.a; opReg = v.o; imm = v.im; scIn = v.s;
        q_exp.push_back({v.er, v.ec, (v.er == 8'd0), v.eb});
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(mk(0, 4'd0, 3'd0, 8'd44, 8'd45, 5'd0, 1'b0, 8'd89, 1'b0, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rslt, scOut, zero, branch} !== {8'd0, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_hold: got rslt=%0d scOut=%b zero=%b branch=%b, want 0/0/1/0", rslt, scOut, zero, branch);
        end
        rst_n = 1'b1;
        #2;
        checks++;
        if ({rslt, scOut, zero, branch} !== {8'd0, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_release_early: got rslt=%0d scOut=%b zero=%b branch=%b, want 0/0/1/0", rslt, scOut, zero, branch);
        end
        @(posedge clk); #1;
        begin
            exp_t e;
            e = q_exp.pop_front();
            checks++;
            if ({rslt, scOut, zero, branch} !== {e.r, e.c, e.z, e.b}) begin
                failures++;
                $display("FAIL reset_first_op: got rslt=%0d scOut=%b zero=%b branch=%b, want rslt=%0d scOut=%b zero=%b branch=%b",
                         rslt, scOut, zero, branch, e.r, e.c, e.z, e.b);
            end
        end
    endtask

    task automatic test_arith;
        vec_t v[$];
        exp_t e;
        v.push_back(mk(0, 4'd0, 3'd0, 8'd44,  8'd45,  5'd0, 1'b0, 8'd89,  1'b0, 1'b0));
        v.push_back(mk(0, 4'd1, 3'd0, 8'd45,  8'd44,  5'd0, 1'b0, 8'd1,   1'b0, 1'b0));
        v.push_back(mk(0, 4'd0, 3'd0, 8'd200, 8'd100, 5'd0, 1'b0, 8'd44,  1'b1, 1'b0));
        v.push_back(mk(0, 4'd0, 3'd0, 8'd255, 8'd0,   5'd0, 1'b1, 8'd0,   1'b1, 1'b0));
        v.push_back(mk(0, 4'd1, 3'd0, 8'd0,   8'd1,   5'd0, 1'b0, 8'd255, 1'b1, 1'b0));
        v.push_back(mk(0, 4'd1, 3'd0, 8'd5,   8'd5,   5'd0, 1'b1, 8'd255, 1'b1, 1'b0));
        v.push_back(mk(0, 4'd0, 3'd0, 8'd127, 8'd1,   5'd0, 1'b0, 8'd128, 1'b0, 1'b0));
        foreach (v[k]) begin
            drive(v[k]);
            @(posedge clk); #1;
            e = q_exp.pop_front();
            checks++;
            if ({rslt, scOut, zero, branch} !== {e.r, e.c, e.z, e.b}) begin
                failures++;
                $display("FAIL arith[%0d]: got rslt=%0d scOut=%b zero=%b branch=%b, want rslt=%0d scOut=%b zero=%b branch=%b",
                         k, rslt, scOut, zero, branch, e.r, e.c, e.z, e.b);
            end
        end
    endtask

    task automatic test_logic_shift;
        vec_t v[$];
        exp_t e;
        v.push_back(mk(0, 4'd2, 3'd0, 8'd44,   8'd45, 5'd0, 1'b1, 8'd44,   1'b0, 1'b0));
        v.push_back(mk(0, 4'd3, 3'd0, 8'd44,   8'd45, 5'd0, 1'b0, 8'd45,   1'b0, 1'b0));
        v.push_back(mk(0, 4'd4, 3'd0, 8'd44,   8'd45, 5'd0, 1'b0, 8'd1,    1'b0, 1'b0));
        v.push_back(mk(0, 4'd5, 3'd0, 8'd44,   8'd45, 5'd0, 1'b0, 8'd0,    1'b0, 1'b0));
        v.push_back(mk(0, 4'd5, 3'd0, 8'd0,    8'd44, 5'd0, 1'b0, 8'd1,    1'b0, 1'b0));
        v.push_back(mk(0, 4'd6, 3'd0, 8'd44,   8'd2,  5'd0, 1'b0, 8'hB0,   1'b0, 1'b0));
        v.push_back(mk(0, 4'd6, 3'd0, 8'h80,   8'd1,  5'd0, 1'b0, 8'd0,    1'b1, 1'b0));
        v.push_back(mk(0, 4'd6, 3'd0, 8'd44,   8'd8,  5'd0, 1'b1, 8'd44,   1'b0, 1'b0));
        v.push_back(mk(0, 4'd7, 3'd0, 8'd44,   8'd2,  5'd0, 1'b0, 8'd11,   1'b0, 1'b0));
        v.push_back(mk(0, 4'd7, 3'd0, 8'd45,   8'd1,  5'd0, 1'b0, 8'd22,   1'b1, 1'b0));
        v.push_back(mk(0, 4'd7, 3'd0, 8'hC0,   8'd7,  5'd0, 1'b0, 8'd1,    1'b1, 1'b0));
        foreach (v[k]) begin
            drive(v[k]);
            @(posedge clk); #1;
            e = q_exp.pop_front();
            checks++;
            if ({rslt, scOut, zero, branch} !== {e.r, e.c, e.z, e.b}) begin
                failures++;
                $display("FAIL logic_shift[%0d]: got rslt=%0d scOut=%b zero=%b branch=%b, want rslt=%0d scOut=%b zero=%b branch=%b",
                         k, rslt, scOut, zero, branch, e.r, e.c, e.z, e.b);
            end
        end
    endtask

    task automatic test_cmp_branch;
        vec_t v[$];
        exp_t e;
        v.push_back(mk(0, 4'd10, 3'd0, 8'd44,  8'd44,  5'd0, 1'b0, 8'd1,   1'b0, 1'b0));
        v.push_back(mk(0, 4'd10, 3'd0, 8'd0,   8'd127, 5'd0, 1'b0, 8'd0,   1'b0, 1'b0));
        v.push_back(mk(0, 4'd11, 3'd0, 8'd44,  8'd45,  5'd0, 1'b0, 8'd1,   1'b0, 1'b0));
        v.push_back(mk(0, 4'd11, 3'd0, 8'd44,  8'd32,  5'd0, 1'b0, 8'd0,   1'b0, 1'b0));
        v.push_back(mk(0, 4'd11, 3'd0, 8'd44,  8'd44,  5'd0, 1'b0, 8'd0,   1'b0, 1'b0));
        v.push_back(mk(0, 4'd11, 3'd0, 8'd255, 8'd1,   5'd0, 1'b0, 8'd1,   1'b0, 1'b0));
        v.push_back(mk(0, 4'd11, 3'd0, 8'd1,   8'd255, 5'd0, 1'b0, 8'd0,   1'b0, 1'b0));
        v.push_back(mk(0, 4'd11, 3'd0, 8'h80,  8'h7F,  5'd0, 1'b0, 8'd1,   1'b0, 1'b0));
        v.push_back(mk(0, 4'd12, 3'd0, 8'd1,   8'd27,  5'd0, 1'b0, 8'd27,  1'b0, 1'b1));
        v.push_back(mk(0, 4'd12, 3'd0, 8'd0,   8'd27,  5'd0, 1'b0, 8'd27,  1'b0, 1'b0));
        v.push_back(mk(0, 4'd12, 3'd0, 8'd0,   8'd0,   5'd0, 1'b0, 8'd0,   1'b0, 1'b0));
        v.push_back(mk(0, 4'd13, 3'd0, 8'd44,  8'd27,  5'd0, 1'b1, 8'd27,  1'b0, 1'b1));
        v.push_back(mk(0, 4'd14, 3'd0, 8'd44,  8'd45,  5'd0, 1'b0, 8'd44,  1'b0, 1'b0));
        v.push_back(mk(0, 4'd14, 3'd0, 8'd0,   8'd45,  5'd0, 1'b0, 8'd0,   1'b0, 1'b0));
        v.push_back(mk(0, 4'd15, 3'd0, 8'd44,  8'd45,  5'd0, 1'b0, 8'd45,  1'b0, 1'b0));
        v.push_back(mk(0, 4'd8,  3'd0, 8'd44,  8'd127, 5'd0, 1'b0, 8'd127, 1'b0, 1'b0));
        v.push_back(mk(0, 4'd9,  3'd0, 8'd44,  8'd127, 5'd0, 1'b0, 8'd127, 1'b0, 1'b0));
        foreach (v[k]) begin
            drive(v[k]);
            @(posedge clk); #1;
            e = q_exp.pop_front();
            checks++;
            if ({rslt, scOut, zero, branch} !== {e.r, e.c, e.z, e.b}) begin
                failures++;
                $display("FAIL cmp_branch[%0d]: got rslt=%0d scOut=%b zero=%b branch=%b, want rslt=%0d scOut=%b zero=%b branch=%b",
                         k, rslt, scOut, zero, branch, e.r, e.c, e.z, e.b);
            end
        end
    endtask

    task automatic test_itype;
        vec_t v[$];
        exp_t e;
        v.push_back(mk(1, 4'd0,  3'd0, 8'd44,  8'd0,   5'd31, 1'b0, 8'd75,  1'b0, 1'b0));
        v.push_back(mk(1, 4'd1,  3'd0, 8'd44,  8'd200, 5'd31, 1'b0, 8'd75,  1'b0, 1'b0));
        v.push_back(mk(1, 4'd0,  3'd0, 8'd250, 8'd0,   5'd31, 1'b1, 8'd26,  1'b1, 1'b0));
        v.push_back(mk(1, 4'd0,  3'd1, 8'd32,  8'd0,   5'd31, 1'b0, 8'd1,   1'b0, 1'b0));
        v.push_back(mk(1, 4'd0,  3'd1, 8'd0,   8'd0,   5'd1,  1'b0, 8'd255, 1'b1, 1'b0));
        v.push_back(mk(1, 4'd0,  3'd2, 8'd44,  8'd255, 5'd13, 1'b0, 8'd12,  1'b0, 1'b0));
        v.push_back(mk(1, 4'd0,  3'd3, 8'd44,  8'd0,   5'd2,  1'b0, 8'hB0,  1'b0, 1'b0));
        v.push_back(mk(1, 4'd0,  3'd3, 8'd255, 8'd0,   5'd31, 1'b0, 8'h80,  1'b1, 1'b0));
        v.push_back(mk(1, 4'd0,  3'd4, 8'd44,  8'd0,   5'd2,  1'b0, 8'd11,  1'b0, 1'b0));
        v.push_back(mk(1, 4'd0,  3'd4, 8'd44,  8'd7,   5'd8,  1'b0, 8'd44,  1'b0, 1'b0));
        v.push_back(mk(1, 4'd0,  3'd5, 8'd44,  8'd45,  5'd25, 1'b0, 8'd25,  1'b0, 1'b0));
        v.push_back(mk(1, 4'd0,  3'd5, 8'd44,  8'd45,  5'd0,  1'b0, 8'd0,   1'b0, 1'b0));
        v.push_back(mk(1, 4'd13, 3'd6, 8'd44,  8'd45,  5'd31, 1'b1, 8'd0,   1'b0, 1'b0));
        v.push_back(mk(1, 4'd0,  3'd7, 8'd200, 8'd100, 5'd31, 1'b1, 8'd0,   1'b0, 1'b0));
        foreach (v[k]) begin
            drive(v[k]);
            @(posedge clk); #1;
            e = q_exp.pop_front();
            checks++;
            if ({rslt, scOut, zero, branch} !== {e.r, e.c, e.z, e.b}) begin
                failures++;
                $display("FAIL itype[%0d]: got rslt=%0d scOut=%b zero=%b branch=%b, want rslt=%0d scOut=%b zero=%b branch=%b",
                         k, rslt, scOut, zero, branch, e.r, e.c, e.z, e.b);
            end
        end
    endtask

    task automatic test_hold;
        exp_t e;
        drive(mk(0, 4'd0, 3'd0, 8'd44, 8'd45, 5'd0, 1'b0, 8'd89, 1'b0, 1'b0));
        @(posedge clk); #1;
        e = q_exp.pop_front();
        drive(mk(0, 4'd14, 3'd0, 8'd0, 8'd45, 5'd0, 1'b0, 8'd0, 1'b0, 1'b0));
        #3;
        checks++;
        if ({rslt, scOut, zero, branch} !== {e.r, e.c, e.z, e.b}) begin
            failures++;
            $display("FAIL hold_between_edges: got rslt=%0d scOut=%b zero=%b branch=%b, want rslt=%0d scOut=%b zero=%b branch=%b",
                     rslt, scOut, zero, branch, e.r, e.c, e.z, e.b);
        end
        @(posedge clk); #1;
        e = q_exp.pop_front();
        checks++;
        if ({rslt, scOut, zero, branch} !== {e.r, e.c, e.z, e.b}) begin
            failures++;
            $display("FAIL hold_next_edge: got rslt=%0d scOut=%b zero=%b branch=%b, want rslt=%0d scOut=%b zero=%b branch=%b",
                     rslt, scOut, zero, branch, e.r, e.c, e.z, e.b);
        end
    endtask

    task automatic test_reset_dominates;
        exp_t e;
        drive(mk(0, 4'd13, 3'd0, 8'd44, 8'd27, 5'd0, 1'b1, 8'd27, 1'b0, 1'b1));
        void'(q_exp.pop_back());
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({rslt, scOut, zero, branch} !== {8'd0, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_dominates: got rslt=%0d scOut=%b zero=%b branch=%b, want 0/0/1/0", rslt, scOut, zero, branch);
        end
        rst_n = 1'b1;
        drive(mk(0, 4'd1, 3'd0, 8'd0, 8'd1, 5'd0, 1'b0, 8'd255, 1'b1, 1'b0));
        @(posedge clk); #1;
        e = q_exp.pop_front();
        checks++;
        if ({rslt, scOut, zero, branch} !== {e.r, e.c, e.z, e.b}) begin
            failures++;
            $display("FAIL reset_dominates_release: got rslt=%0d scOut=%b zero=%b branch=%b, want rslt=%0d scOut=%b zero=%b branch=%b",
                     rslt, scOut, zero, branch, e.r, e.c, e.z, e.b);
        end
    endtask

    task automatic test_back_to_back;
        vec_t v;
        exp_t e;
        for (int n = 0; n < 300; n++) begin
            v = '0;
            v.tc = 1'($urandom_range(0, 1));
            v.r  = 4'($urandom_range(0, 15));
            v.i  = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0:       v.a = 8'd0;
                1:       v.a = 8'd255;
                default: v.a = 8'($urandom);
            endcase
            v.o  = 8'($urandom);
            v.im = 5'($urandom);
            v.s  = 1'($urandom_range(0, 1));
            v = model(v);
            drive(v);
            @(posedge clk); #1;
            e = q_exp.pop_front();
            checks++;
            if ({rslt, scOut, zero, branch} !== {e.r, e.c, e.z, e.b}) begin
                failures++;
                $display("FAIL back_to_back[%0d] tc=%b rOp=%0d iOp=%0d acc=%0d opReg=%0d imm=%0d scIn=%b: got rslt=%0d scOut=%b zero=%b branch=%b, want rslt=%0d scOut=%b zero=%b branch=%b",
                         n, v.tc, v.r, v.i, v.a, v.o, v.im, v.s, rslt, scOut, zero, branch, e.r, e.c, e.z, e.b);
            end
        end
        checks++;
        if (q_exp.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", q_exp.size());
        end
    endtask

    initial begin
        rst_n = 1'b0; acc = '0; opReg = '0; imm = '0;
        typeCode = 1'b0; rOp = '0; iOp = '0; scIn = 1'b0;
        test_reset;
        test_arith;
        test_logic_shift;
        test_cmp_branch;
        test_itype;
        test_hold;
        test_reset_dominates;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
